// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: a bank of BITS JK flip-flops shared by N_REQ requesters.
// A round-robin arbiter grants one requester per cycle. The granted {j,k} command
// is applied to the addressed bit on the next clock edge.
// Optional build macro JK_BANK_PRIO0_EN: requester 0 gets fixed top priority,
// and requesters 1..N_REQ-1 rotate among themselves.
module jk_bank_arbiter #(
   parameter int N_REQ = 4,
   parameter int BITS  = 6,
   parameter int AW    = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ-1:0]           req_j,
   input  logic [N_REQ-1:0]           req_k,
   input  logic [N_REQ*AW-1:0]        req_addr,
   output logic [N_REQ-1:0]           gnt,
   output logic [$clog2(N_REQ)-1:0]   gnt_id,
   output logic [BITS-1:0]            q,
   output logic                       err
);

   localparam int IDW = $clog2(N_REQ);
   // Widened by one bit so the comparison stays correct when 2**AW == BITS.
   localparam logic [AW:0] ADDR_LIM = (AW+1)'(BITS);

`ifdef JK_BANK_PRIO0_EN
   localparam bit PRIO0 = 1'b1;
`else
   localparam bit PRIO0 = 1'b0;
`endif

   logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
   logic [IDW-1:0]  gnt_id_reg;
   logic            err_reg;
   logic [BITS-1:0] q_reg, q_next;

   logic [IDW-1:0]  gnt_idx;
   logic            gnt_valid;
   logic            sel_j, sel_k;
   logic [AW-1:0]   sel_addr;
   logic            addr_ok;

   // Arbitration: first asserted req at or after rr_ptr, wrapping; req0 may preempt.
   always_comb begin : arb
      int  idx;
      logic found;
      found   = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      if (PRIO0 && req[0]) begin
         found   = 1'b1;
         gnt_idx = '0;
      end
      for (int off = 0; off < N_REQ; off++) begin
         idx = (int'(rr_ptr_reg) + off) % N_REQ;
         // In priority mode requester 0 never takes part in the rotation.
         if (!found && req[idx] && !(PRIO0 && idx == 0)) begin
            found   = 1'b1;
            gnt_idx = IDW'(idx);
         end
      end
      gnt_valid = found;
   end

   // One-hot grant, held at zero while reset is asserted.
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
         assign gnt[gi] = !rst && gnt_valid && (gnt_idx == IDW'(gi));
      end
   endgenerate

   // Select the command of the granted requester.
   always_comb begin
      sel_j    = 1'b0;
      sel_k    = 1'b0;
      sel_addr = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_idx == IDW'(i)) begin
            sel_j    = req_j[i];
            sel_k    = req_k[i];
            sel_addr = req_addr[i*AW +: AW];
         end
      end
   end

   assign addr_ok = ({1'b0, sel_addr} < ADDR_LIM);

   // Pointer advance: past the winner, except when requester 0 wins by priority.
   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (gnt_valid && !(PRIO0 && gnt_idx == '0)) begin
         if (gnt_idx == IDW'(N_REQ-1))
            rr_ptr_next = '0;
         else
            rr_ptr_next = gnt_idx + IDW'(1);
      end
   end

   // Per-bit JK next state: only the addressed bit of a granted command changes.
   generate
      for (genvar gi = 0; gi < BITS; gi++) begin : g_bank
         localparam logic [AW-1:0] BIT_ADDR = AW'(gi);
         logic hit;
         assign hit = gnt_valid && (sel_addr == BIT_ADDR);
         assign q_next[gi] = !hit             ? q_reg[gi] :
                             ( sel_j &&  sel_k) ? ~q_reg[gi] :
                             ( sel_j && !sel_k) ? 1'b1 :
                             (!sel_j &&  sel_k) ? 1'b0 : q_reg[gi];
      end
   endgenerate

   // State registers: bank, pointer, last grant index and the range-error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_reg      <= '0;
         rr_ptr_reg <= '0;
         gnt_id_reg <= '0;
         err_reg    <= 1'b0;
      end else begin
         q_reg      <= q_next;
         rr_ptr_reg <= rr_ptr_next;
         err_reg    <= gnt_valid && !addr_ok;
         if (gnt_valid)
            gnt_id_reg <= gnt_idx;
      end
   end

   assign q      = q_reg;
   assign gnt_id = gnt_id_reg;
   assign err    = err_reg;

endmodule
